// File: rtl/prio_pkg.sv
// Shared encoder-family definitions: scan FSM state encoding and the
// zero-extended bit-index width used on every encoder output.
package prio_pkg;

   localparam int IDX_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

endpackage

// File: rtl/prio_find.sv
// Combinational priority finder: locates the highest or lowest set bit of x_i
// with a log2(WIDTH)-step halving search, and flags words with one bit set.
module prio_find
   import prio_pkg::*;
#(
   parameter int  WIDTH_LOG = 4,
   parameter bit  MSB_FIRST = 1'b1,
   localparam int WIDTH     = 1 << WIDTH_LOG
) (
   input  logic [WIDTH-1:0]     x_i,
   output logic [WIDTH_LOG-1:0] idx_o,
   output logic                 one_o
);

   logic [WIDTH-1:0] win, hi, lo, mask;

   // Each step decides one index bit, from the MSB down, by picking the half
   // of the current window that holds the wanted bit; the window is kept
   // right-aligned so the next step always looks at bits [2^s-1:0].
   always_comb begin
      win   = x_i;
      hi    = '0;
      lo    = '0;
      mask  = '0;
      idx_o = '0;
      for (int s = WIDTH_LOG - 1; s >= 0; s--) begin
         mask = {WIDTH{1'b1}} >> (WIDTH - (1 << s));
         hi   = (win >> (1 << s)) & mask;
         lo   = win & mask;
         if (MSB_FIRST) begin
            idx_o[s] = |hi;
            win      = (|hi) ? hi : lo;
         end else begin
            idx_o[s] = ~|lo;
            win      = (|lo) ? lo : hi;
         end
      end
   end

   assign one_o = (x_i != '0) && ((x_i & (x_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/prio_scan.sv
// Set-bit scanner: loads a word, then streams the index of each set bit, one
// per cycle. Define PRIO_SCAN_EMPTY_EN to report an all-zero word as one beat.
module prio_scan
   import prio_pkg::*;
#(
   parameter int  WIDTH_LOG = 4,
   parameter bit  MSB_FIRST = 1'b1,
   localparam int WIDTH     = 1 << WIDTH_LOG
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_empty
);

`ifdef PRIO_SCAN_EMPTY_EN
   localparam bit EMPTY_EN = 1'b1;
`else
   localparam bit EMPTY_EN = 1'b0;
`endif

   if (WIDTH_LOG < 1 || WIDTH_LOG > 8) begin : g_bad_width
      $error("prio_scan: WIDTH_LOG must be within 1..8");
   end

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic                 empty_q, empty_d;
   logic [WIDTH_LOG-1:0] find_idx;
   logic                 find_one;

   prio_find #(
      .WIDTH_LOG (WIDTH_LOG),
      .MSB_FIRST (MSB_FIRST)
   ) u_find (
      .x_i   (rem_q),
      .idx_o (find_idx),
      .one_o (find_one)
   );

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      empty_d   = empty_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_idx   = '0;
      out_last  = 1'b0;
      out_empty = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               rem_d   = in_x;
               empty_d = EMPTY_EN && (in_x == '0);
               if (in_x != '0 || EMPTY_EN) state_d = SCAN;
            end
         end
         SCAN: begin
            out_valid = 1'b1;
            // An empty-word beat has rem = 0, where the finder result is
            // meaningless, so the index is forced to 0.
            out_idx   = empty_q ? '0 : IDX_W'(find_idx);
            out_last  = find_one | empty_q;
            out_empty = empty_q;
            if (out_ready) begin
               rem_d = rem_q & ~(WIDTH'(1) << find_idx);
               if (out_last) begin
                  state_d = IDLE;
                  empty_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         empty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         empty_q <= empty_d;
      end
   end

endmodule

// File: doc/prio_scan.md
PRIO_SCAN -- requirements
Module: prio_scan

Interface
REQ-001 Parameter WIDTH_LOG, default 4, log2 of input word width; WIDTH = 1 << WIDTH_LOG; legal range 1..8.
REQ-002 Parameter MSB_FIRST, default 1; 1 = emit set-bit indices highest first, 0 = lowest first.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  in_x holds a word to scan.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 in_x  input  WIDTH  word to scan.
REQ-008 out_valid  output  1  out_idx/out_last/out_empty hold a valid beat.
REQ-009 out_ready  input  1  consumer accepts the current beat.
REQ-010 out_idx  output  8  bit index of the current set bit, zero-extended.
REQ-011 out_last  output  1  current beat is the final beat for the loaded word.
REQ-012 out_empty  output  1  current beat reports an all-zero word (PRIO_SCAN_EMPTY_EN only; tied 0 otherwise).

Function
REQ-013 Two states, IDLE and SCAN; encoding binary, IDLE = 0.
REQ-014 IDLE: in_ready = 1, out_valid = 0.
REQ-015 IDLE with in_valid = 1 and in_x != 0: register in_x into remaining-mask register rem; next state SCAN.
REQ-016 Load-to-output latency is exactly one cycle: out_valid = 1 in the cycle after the accepting edge.
REQ-017 SCAN: in_ready = 0, out_valid = 1; out_idx = index of the highest (MSB_FIRST=1) or lowest (MSB_FIRST=0) set bit of rem, computed combinationally from rem.
REQ-018 SCAN: out_last = 1 iff rem has exactly one bit set.
REQ-019 Output handshake (out_valid & out_ready) clears the bit at out_idx in rem; the next beat appears in the following cycle, giving one index per cycle at full throughput.
REQ-020 Handshake with out_last = 1: next state IDLE; in_ready = 1 in the following cycle (one bubble cycle between words).
REQ-021 out_ready = 0 in SCAN: rem, out_idx, out_last and out_empty hold stable until the handshake.
REQ-022 A word with k set bits produces exactly k beats, indices strictly decreasing (MSB_FIRST=1) or strictly increasing (MSB_FIRST=0).
REQ-023 in_x and in_valid are ignored outside the IDLE accept cycle; a held in_valid is not double-accepted.

Reset
REQ-024 rst = 1 at a rising edge: state = IDLE, rem = 0, out_valid = 0, out_idx = 0, out_last = 0, out_empty = 0, in_ready = 1 from the next cycle.
REQ-025 Reset mid-scan discards the remaining indices; no further beats for that word.
REQ-026 Reset has priority over load and over output handshake in the same cycle.

Configuration
REQ-027 Macro PRIO_SCAN_EMPTY_EN defined: IDLE accept of in_x == 0 enters SCAN and emits exactly one beat with out_empty = 1, out_idx = 0, out_last = 1, obeying REQ-019..021.
REQ-028 Macro PRIO_SCAN_EMPTY_EN undefined: IDLE accept of in_x == 0 is consumed silently, state stays IDLE, no beat emitted; out_empty is constant 0.

Structure
REQ-029 Shared package prio_pkg holds the state encoding constants (IDLE, SCAN) and the 8-bit index width constant, shared with the other encoder blocks.
REQ-030 One sub-module, prio_find: combinational WIDTH-to-index finder parametrised by WIDTH_LOG and MSB_FIRST, built as a WIDTH_LOG-stage halving search; also outputs a single-bit-set flag for out_last.
REQ-031 Elaboration-time check via the codebase assertion macros: WIDTH_LOG in 1..8.

Verification (WIDTH_LOG = 4)
REQ-032 MSB_FIRST=1, in_x=0x8421, out_ready=1 -> out_idx 15,10,5,0 on four consecutive cycles, out_last only on 0, in_ready = 1 the cycle after.
REQ-033 MSB_FIRST=0, in_x=0x8421 -> out_idx 0,5,10,15; in_x=0xFFFF -> 16 beats 0..15, out_last on 15.
REQ-034 in_x=0x0090, out_ready low 3 cycles after out_valid rises -> out_idx=7 held stable 3 cycles, then 7,4 on handshakes.
REQ-035 in_x=0x0000: with PRIO_SCAN_EMPTY_EN -> one beat out_empty=1, out_idx=0, out_last=1; without -> no beat, in_ready stays 1.
REQ-036 in_x=0xF000, rst asserted after beats 15,14 -> out_valid=0 next cycle, in_ready=1; new word 0x0001 -> single beat idx 0, out_last=1.
